reg_fifo_prog: RTL and testbench
================================

Name: reg_fifo_prog

Overview:
Single-clock, register-based synchronous FIFO. It extends the existing register FIFO with:
- runtime-programmable almost-full and almost-empty thresholds;
- a synchronous flush input;
- non-power-of-2 depth support;
- full-with-simultaneous-read write acceptance;
- an occupancy count output;
- sticky overflow and underflow error flags;
- a selectable output mode: show-ahead (FWFT) or registered read data.

It is the default buffering primitive for datapath blocks that need back-pressure status tuned by software.

Parameters:
- DATA_W, 8, data width in bits (≥1).
- DEPTH, 8, number of entries (≥2, any integer, not restricted to a power of 2).
- REG_OUT, 0, output mode. 0 = show-ahead (FWFT); 1 = registered read data, valid one cycle after an accepted read.
- CNT_W, $clog2(DEPTH+1), width of the count and threshold ports (derived; do not override).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- i_flush  in  1  synchronous flush; empties the FIFO.
- i_wren  in  1  write request.
- i_wrdata  in  DATA_W  write data.
- o_full  out  1  FIFO full.
- o_alm_full  out  1  almost full.
- i_rden  in  1  read request.
- o_rddata  out  DATA_W  read data.
- o_rdvalid  out  1  REG_OUT=1: o_rddata valid this cycle. REG_OUT=0: equals !o_empty.
- o_empty  out  1  FIFO empty.
- o_alm_empty  out  1  almost empty.
- i_upp_th  in  CNT_W  almost-full threshold.
- i_low_th  in  CNT_W  almost-empty threshold.
- o_dcount  out  CNT_W  current occupancy.
- o_ovf  out  1  sticky overflow flag.
- o_udf  out  1  sticky underflow flag.
- i_clr_err  in  1  clears o_ovf and o_udf.

Behaviour:
- Reset (rst=1, asynchronous):
  - Pointers, count, o_ovf, o_udf, o_rdvalid and the REG_OUT output register all go to 0.
  - Storage array is not reset.
  - o_empty=1, o_full=0, o_dcount=0.
  - o_alm_empty=1 if i_low_th≥0, which always holds.
  - o_alm_full=1 only if i_upp_th==0.
- Read acceptance: rd_acc = i_rden & !empty.
- Write acceptance: wr_acc = i_wren & (!full | rd_acc). A write is accepted while full if a read is accepted in the same cycle.
- Pointers:
  - Each pointer is $clog2(DEPTH) bits and increments on acceptance.
  - Each wraps from DEPTH-1 to 0 explicitly; pointer values ≥DEPTH are never reached.
- Count update each cycle:
  - +1 on wr_acc only;
  - -1 on rd_acc only;
  - unchanged when both or neither occur.
- Status flags (all combinational from the count register, zero-cycle latency):
  - o_full = (count==DEPTH)
  - o_empty = (count==0)
  - o_alm_full = (count ≥ i_upp_th)
  - o_alm_empty = (count ≤ i_low_th)
- Thresholds are sampled combinationally and may change any cycle. Out-of-range thresholds are legal; for example, i_upp_th > DEPTH means o_alm_full is never asserted.
- Flush (i_flush=1, synchronous):
  - Next cycle: pointers=0, count=0, o_rdvalid=0.
  - wr_acc and rd_acc are forced to 0 in the flush cycle, so no data is stored and no count change occurs.
  - Error flags are unaffected.
- Overflow: i_wren & !wr_acc & !i_flush sets o_ovf on the next edge.
- Underflow: i_rden & !rd_acc & !i_flush sets o_udf on the next edge.
- Error flags hold until i_clr_err. If i_clr_err and a new error event occur in the same cycle, the set wins.
- REG_OUT=0 (show-ahead):
  - o_rddata = mem[rdptr], combinational.
  - Value is undefined while empty.
  - A read in cycle N advances the head at edge N+1.
- REG_OUT=1 (registered):
  - On rd_acc at edge N: the output register loads mem[rdptr] and o_rdvalid=1 during cycle N+1.
  - Without rd_acc, o_rdvalid=0 and o_rddata holds its previous value.
  - Read latency is exactly 1 cycle.
- Simultaneous read and write while empty:
  - Only the write is accepted, since rd_acc=0.
  - Count goes 0→1.
  - o_udf is set because i_rden was asserted while empty.
- Simultaneous read and write at count=DEPTH:
  - Both are accepted; count stays at DEPTH.
  - The written entry occupies the slot freed by the read (wrptr==rdptr when full).
- Reset asserted mid-operation: immediate clear, as defined under Reset. Contents are lost logically.

Test Plan:
- Fill and drain (DEPTH=6, REG_OUT=0): write 6 words 0x11..0x16, then read 6.
  - o_full=1 after the 6th write and o_dcount=6.
  - Reads return 0x11..0x16 in order.
  - o_empty=1 at the end; wrptr and rdptr each wrapped 5→0.
- Full with simultaneous read/write: at count=6, assert i_wren with 0xAA and i_rden together.
  - Count stays 6 and o_ovf stays 0.
  - Draining then returns 0x12..0x16, 0xAA.
- Errors: write while full without a read, then read while empty.
  - o_ovf=1, then o_udf=1, both sticky.
  - i_clr_err clears both the next cycle.
  - An error coincident with i_clr_err leaves that flag set.
- Programmable thresholds: i_upp_th=4, i_low_th=1.
  - o_alm_full rises when count reaches 4; o_alm_empty clears when count reaches 2.
  - Changing i_upp_th to 2 with count=3 asserts o_alm_full in the same cycle.
- Flush and reset: with count=3, pulse i_flush.
  - Next cycle: count=0, o_empty=1.
  - A write with 0x5A accepted after the flush reads back as 0x5A.
  - Asserting rst mid-burst clears count and flags asynchronously, with no clock edge.
- Registered mode (REG_OUT=1): write 0x01, 0x02, then read twice back-to-back.
  - o_rdvalid=1 with 0x01 one cycle after the first read and 0x02 the following cycle.
  - o_rdvalid=0 afterward, with o_rddata holding 0x02.

Source files
------------

// File: rtl/reg_fifo_prog.sv
// Register-based single-clock FIFO with programmable almost-full/almost-empty
// thresholds, synchronous flush, sticky error flags and selectable output mode.
module reg_fifo_prog #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int REG_OUT = 0,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  output logic              o_full,
  output logic              o_alm_full,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_rdvalid,
  output logic              o_empty,
  output logic              o_alm_empty,
  input  logic [CNT_W-1:0]  i_upp_th,
  input  logic [CNT_W-1:0]  i_low_th,
  output logic [CNT_W-1:0]  o_dcount,
  output logic              o_ovf,
  output logic              o_udf,
  input  logic              i_clr_err
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wrptr;
  logic [PTR_W-1:0]  rdptr;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              rd_acc;
  logic              wr_acc;
  logic              ovf_set;
  logic              udf_set;
  logic              ovf;
  logic              udf;

  // Explicit wrap keeps non-power-of-2 depths from ever reaching DEPTH..2^PTR_W-1.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // A full FIFO still takes a write when a read frees the head slot this cycle.
  assign rd_acc  = i_rden & ~empty & ~i_flush;
  assign wr_acc  = i_wren & (~full | rd_acc) & ~i_flush;
  assign ovf_set = i_wren & ~wr_acc & ~i_flush;
  assign udf_set = i_rden & ~rd_acc & ~i_flush;

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wrptr] <= i_wrdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else if (i_flush) begin
      wrptr <= '0;
      rdptr <= '0;
      count <= '0;
    end else begin
      if (wr_acc) begin
        wrptr <= ptr_inc(wrptr);
      end
      if (rd_acc) begin
        rdptr <= ptr_inc(rdptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= sticky_next(ovf, ovf_set, i_clr_err);
      udf <= sticky_next(udf, udf_set, i_clr_err);
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [DATA_W-1:0] rddata_p1;
      logic              vld_p1;

      // Stage p1: head word captured on an accepted read, valid for one cycle.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rddata_p1 <= '0;
          vld_p1    <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) begin
            rddata_p1 <= mem[rdptr];
          end
        end
      end

      assign o_rddata  = rddata_p1;
      assign o_rdvalid = vld_p1;
    end else begin : g_fwft
      assign o_rddata  = mem[rdptr];
      assign o_rdvalid = ~empty;
    end
  endgenerate

  assign o_full      = full;
  assign o_empty     = empty;
  assign o_alm_full  = (count >= i_upp_th);
  assign o_alm_empty = (count <= i_low_th);
  assign o_dcount    = count;
  assign o_ovf       = ovf;
  assign o_udf       = udf;

endmodule

// File: tb/tb_reg_fifo_prog.sv
// Bench for reg_fifo_prog: a show-ahead and a registered-output instance share
// one stimulus stream and are compared against a queue-based reference model.
module tb_reg_fifo_prog;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 6;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              wren;
  logic [DATA_W-1:0] wrdata;
  logic              rden;
  logic [CNT_W-1:0]  upp_th;
  logic [CNT_W-1:0]  low_th;
  logic              clr_err;

  logic              a_full, a_alm_full, a_rdvalid, a_empty, a_alm_empty, a_ovf, a_udf;
  logic [DATA_W-1:0] a_rddata;
  logic [CNT_W-1:0]  a_dcount;
  logic              b_full, b_alm_full, b_rdvalid, b_empty, b_alm_empty, b_ovf, b_udf;
  logic [DATA_W-1:0] b_rddata;
  logic [CNT_W-1:0]  b_dcount;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  logic [DATA_W-1:0] q [$];
  logic              ovf_m;
  logic              udf_m;
  logic [DATA_W-1:0] reg_m;
  logic              vld_m;

  always #5 clk = ~clk;

  reg_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_OUT(0)) dut_a (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata),
    .o_full(a_full), .o_alm_full(a_alm_full), .i_rden(rden), .o_rddata(a_rddata),
    .o_rdvalid(a_rdvalid), .o_empty(a_empty), .o_alm_empty(a_alm_empty),
    .i_upp_th(upp_th), .i_low_th(low_th), .o_dcount(a_dcount),
    .o_ovf(a_ovf), .o_udf(a_udf), .i_clr_err(clr_err)
  );

  reg_fifo_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .REG_OUT(1)) dut_b (
    .clk(clk), .rst(rst), .i_flush(flush), .i_wren(wren), .i_wrdata(wrdata),
    .o_full(b_full), .o_alm_full(b_alm_full), .i_rden(rden), .o_rddata(b_rddata),
    .o_rdvalid(b_rdvalid), .o_empty(b_empty), .o_alm_empty(b_alm_empty),
    .i_upp_th(upp_th), .i_low_th(low_th), .o_dcount(b_dcount),
    .o_ovf(b_ovf), .o_udf(b_udf), .i_clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    chk("a_dcount",    32'(a_dcount),    32'(n));
    chk("a_full",      32'(a_full),      32'(n == DEPTH));
    chk("a_empty",     32'(a_empty),     32'(n == 0));
    chk("a_alm_full",  32'(a_alm_full),  32'(n >= int'(upp_th)));
    chk("a_alm_empty", 32'(a_alm_empty), 32'(n <= int'(low_th)));
    chk("a_ovf",       32'(a_ovf),       32'(ovf_m));
    chk("a_udf",       32'(a_udf),       32'(udf_m));
    chk("a_rdvalid",   32'(a_rdvalid),   32'(n != 0));
    if (n != 0) begin
      chk("a_rddata_head", 32'(a_rddata), 32'(q[0]));
    end
    chk("b_dcount",    32'(b_dcount),    32'(n));
    chk("b_full",      32'(b_full),      32'(n == DEPTH));
    chk("b_empty",     32'(b_empty),     32'(n == 0));
    chk("b_alm_full",  32'(b_alm_full),  32'(n >= int'(upp_th)));
    chk("b_alm_empty", 32'(b_alm_empty), 32'(n <= int'(low_th)));
    chk("b_ovf",       32'(b_ovf),       32'(ovf_m));
    chk("b_udf",       32'(b_udf),       32'(udf_m));
    chk("b_rdvalid",   32'(b_rdvalid),   32'(vld_m));
    chk("b_rddata",    32'(b_rddata),    32'(reg_m));
  endtask

  task automatic model_reset();
    q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    reg_m = '0;
    vld_m = 1'b0;
  endtask

  // One clock cycle: drive at the falling edge, check before the rising edge,
  // then advance the model by what that rising edge will do.
  task automatic step(input logic wr, input logic [DATA_W-1:0] d, input logic rd,
                      input logic fl, input logic clr);
    logic ra, wa, ovs, uds;
    wren = wr; wrdata = d; rden = rd; flush = fl; clr_err = clr;
    #1;
    check_outputs();
    ra  = rd & (q.size() != 0) & ~fl;
    wa  = wr & ((q.size() < DEPTH) | ra) & ~fl;
    ovs = wr & ~wa & ~fl;
    uds = rd & ~ra & ~fl;
    if (fl) begin
      q.delete();
      vld_m = 1'b0;
    end else begin
      vld_m = ra;
      if (ra) reg_m = q.pop_front();
      if (wa) q.push_back(d);
    end
    ovf_m = ovs | (ovf_m & ~clr);
    udf_m = uds | (udf_m & ~clr);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; flush = 0; wren = 0; wrdata = '0; rden = 0; clr_err = 0;
    upp_th = '0; low_th = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Fill and drain with pointer wrap
    upp_th = 3'd7; low_th = 3'd0;
    for (int i = 0; i < 6; i++) step(1, 8'h11 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Full with simultaneous read and write
    for (int i = 0; i < 6; i++) step(1, 8'h11 + 8'(i), 0, 0, 0);
    step(1, 8'hAA, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Sticky errors and clear
    for (int i = 0; i < 6; i++) step(1, 8'h30 + 8'(i), 0, 0, 0);
    step(1, 8'hEE, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 1, 0, 1);
    step(1, 8'h77, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 1);

    // Programmable thresholds
    upp_th = 3'd4; low_th = 3'd1;
    for (int i = 0; i < 5; i++) step(1, 8'h40 + 8'(i), 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    upp_th = 3'd2;
    step(0, 8'h00, 0, 0, 0);

    // Flush (write during flush is dropped without raising overflow)
    step(1, 8'h99, 1, 1, 0);
    step(1, 8'h5A, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Registered-mode back-to-back reads
    upp_th = 3'd7; low_th = 3'd0;
    step(1, 8'h01, 0, 0, 0);
    step(1, 8'h02, 0, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    step(0, 8'h00, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0);

    // Asynchronous reset mid-burst, observed before any clock edge
    for (int i = 0; i < 3; i++) step(1, 8'h60 + 8'(i), 0, 0, 0);
    step(1, 8'h63, 1, 0, 0);
    step(0, 8'h00, 1, 0, 0);
    wren = 0; rden = 0; flush = 0; clr_err = 0;
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Randomized traffic with random thresholds
    for (int i = 0; i < 600; i++) begin
      upp_th = CNT_W'($urandom_range(0, 7));
      low_th = CNT_W'($urandom_range(0, 7));
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 50),
           1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 8));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
